fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC0, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK input 1: the single clock, rising-edge.
REQ-003 SHALL have port RST input 1: reset, asynchronous and active-high.
REQ-004 SHALL have port ihit input 1: instruction memory returned valid data this cycle.
REQ-005 SHALL have port imemload input word_t: the instruction word from instruction memory.
REQ-006 SHALL have port pc_en input 1: PC advance enable, driven by the hazard unit.
REQ-007 SHALL have port flushed1 input 1: IF/ID flush request, driven by the hazard unit.
REQ-008 SHALL have port id_en1 input 1: IF/ID latch enable, driven by the hazard unit.
REQ-009 SHALL have port pc_src input PCSrc_t: next-PC source from EX.
REQ-010 SHALL have port branch_sel input 1: branch condition resolved as taken.
REQ-011 SHALL have ports branch_addr, jump_addr and jr_addr, each input word_t: the redirect targets.
REQ-012 SHALL have port halt input 1: halt instruction committed downstream.
REQ-013 SHALL have port imemREN output 1: instruction read enable.
REQ-014 SHALL have port imemaddr output word_t: the current PC.
REQ-015 SHALL have ports instr_id and npc_id, each output word_t: the IF/ID latched instruction and PC+4.
REQ-016 SHALL have port valid_id output 1: the IF/ID slot holds a real instruction.

Function
REQ-017 SHALL form the redirect request (redir) as pc_src==PC_J, pc_src==PC_JR, or (pc_src==PC_BR and branch_sel); the target is jump_addr, jr_addr or branch_addr respectively.
REQ-018 SHALL compute PC+4 modulo 2^32, so that 32'hFFFFFFFC wraps to 32'h00000000.
REQ-019 SHALL implement a 3-state FSM with states FETCH, PEND and HALT.
REQ-020 In FETCH with pc_en=1, SHALL load the PC with the redir target if redir is active, else with PC+4.
REQ-021 In FETCH with pc_en=0 and redir=1, SHALL capture the target into pend_target and go to PEND; the PC holds.
REQ-022 In PEND with pc_en=0, SHALL hold the PC; a new redir overwrites pend_target, so the newest redirect wins.
REQ-023 In PEND with pc_en=1, SHALL load the PC with the current redir target if active, else with pend_target, and return to FETCH.
REQ-024 In any state, halt=1 SHALL go to HALT, clear the pending state and freeze the PC; halt has priority over redir and pc_en in the same cycle.
REQ-025 HALT SHALL be exited only by RST.
REQ-026 imemREN SHALL be 1 in FETCH and PEND, and 0 in HALT.
REQ-027 imemaddr SHALL equal the registered PC, with zero-cycle latency from the PC register.
REQ-028 The IF/ID latch SHALL clear on flushed1=1 (instr_id=0, npc_id=0, valid_id=0); flush has priority over id_en1.
REQ-029 The IF/ID latch SHALL, when id_en1=1 and not flushed, load instr_id=imemload, npc_id=imemaddr+4 and valid_id=ihit.
REQ-030 The IF/ID latch SHALL hold all of its outputs when neither flushed1 nor id_en1 is asserted.
REQ-031 In HALT, SHALL force valid_id=0 on the next edge, regardless of id_en1.

Reset
REQ-032 RST=1 SHALL immediately, without waiting for a clock edge, force PC=PC0, state FETCH, pend_target=0, instr_id=0, npc_id=0 and valid_id=0.
REQ-033 imemREN SHALL be 0 while RST=1, and SHALL be 1 from the first edge after release.
REQ-034 RST asserted mid-redirect or while in HALT SHALL discard all pending state.

Configuration
REQ-035 With FETCH_PERF_CNT_EN defined, SHALL add 32-bit outputs fetch_cnt and stall_cnt, both reset to 0.
REQ-036 With FETCH_PERF_CNT_EN defined, fetch_cnt SHALL increment on every edge where id_en1=1, flushed1=0 and ihit=1.
REQ-037 With FETCH_PERF_CNT_EN defined, stall_cnt SHALL increment on every edge in FETCH or PEND where pc_en=0; both counters wrap at 2^32.
REQ-038 Without FETCH_PERF_CNT_EN, the counter ports and their logic SHALL be absent.

Structure
REQ-039 PCSrc_t SHALL be a 2-bit enum defined in diaosi_types_pkg with PC_SEQ=0, PC_BR=1, PC_J=2 and PC_JR=3.
REQ-040 The fetch FSM state enum SHALL also be defined in diaosi_types_pkg; word_t comes from cpu_types_pkg.
REQ-041 The IF/ID latch SHALL be a sub-module named if_id_latch; the PC, pending-redirect register and FSM stay in fetch_unit.

Verification
REQ-042 Drive reset release with pc_en=1 and ihit=1 for 3 cycles -> imemaddr = 0, 4, 8, C.
REQ-043 At PC=0x10, drive pc_src=PC_BR with branch_sel=1, branch_addr=0x40 and pc_en=1 -> next imemaddr=0x40; with branch_sel=0 -> next imemaddr=0x14.
REQ-044 Drive pc_en=0 with pc_src=PC_J, jump_addr=0x80, then pc_src=PC_JR with jr_addr=0xC0, then pc_en=1 with PC_SEQ -> state PEND, then imemaddr=0xC0.
REQ-045 Drive flushed1=1 and id_en1=1 together while imemload=0x8C220004 -> instr_id=0 and valid_id=0.
REQ-046 Drive halt=1 and redir to 0x40 in the same cycle -> state HALT, imemREN=0, PC frozen; a following RST returns PC to PC0.
REQ-047 At PC=0xFFFFFFFC with pc_en=1 -> PC wraps to 0x0; with FETCH_PERF_CNT_EN, 5 stall cycles -> stall_cnt=5.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage.
//   cpu_types_pkg     : machine word type
//   diaosi_types_pkg  : next-PC source and fetch FSM state enums
//   fetch_unit_pkg    : fetch-local constants and helpers
package cpu_types_pkg;
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;
endpackage

package diaosi_types_pkg;
   typedef enum logic [1:0] {
      PC_SEQ = 2'd0,
      PC_BR  = 2'd1,
      PC_J   = 2'd2,
      PC_JR  = 2'd3
   } PCSrc_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      PEND  = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;
endpackage

package fetch_unit_pkg;
   import cpu_types_pkg::*;

   localparam word_t PC_STEP = 32'd4;

   // Sequential successor; the add is 32 bits wide so the top of memory wraps to 0.
   function automatic word_t pc_plus4(input word_t pc);
      return pc + PC_STEP;
   endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage.
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if;
   import cpu_types_pkg::*;

   logic  ihit;
   word_t imemload;
   logic  imemREN;
   word_t imemaddr;

   modport master (input ihit, input imemload, output imemREN, output imemaddr);
   modport slave  (output ihit, output imemload, input imemREN, input imemaddr);
endinterface

// File: rtl/fetch_unit_if_id_latch.sv
// IF/ID pipeline register: flush clears, enable loads, otherwise hold.
// While the fetch unit is halted the valid bit is forced low.
module if_id_latch
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  i_flush,
   input  logic  i_en,
   input  logic  i_halted,
   input  logic  i_hit,
   input  word_t i_instr,
   input  word_t i_npc,
   output word_t o_instr,
   output word_t o_npc,
   output logic  o_valid
);

   word_t r_instr;
   word_t r_npc;
   logic  r_valid;

   // Flush beats enable; halted state suppresses valid.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_instr <= 32'h0;
         r_npc   <= 32'h0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_instr <= 32'h0;
         r_npc   <= 32'h0;
         r_valid <= 1'b0;
      end else if (i_en) begin
         r_instr <= i_instr;
         r_npc   <= i_npc;
         r_valid <= i_hit & ~i_halted;
      end else if (i_halted) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign o_instr = r_instr;
   assign o_npc   = r_npc;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, pending-redirect register and FETCH/PEND/HALT FSM,
// feeding the IF/ID latch.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt counters.
module fetch_unit
   import cpu_types_pkg::*;
   import diaosi_types_pkg::*;
   import fetch_unit_pkg::*;
#(
   parameter word_t PC0 = 32'h00000000
)(
   input  logic          CLK,
   input  logic          RST,
   fetch_unit_if.master  imem,
   input  logic          pc_en,
   input  logic          flushed1,
   input  logic          id_en1,
   input  PCSrc_t        pc_src,
   input  logic          branch_sel,
   input  word_t         branch_addr,
   input  word_t         jump_addr,
   input  word_t         jr_addr,
   input  logic          halt,
   output word_t         instr_id,
   output word_t         npc_id,
   output logic          valid_id
`ifdef FETCH_PERF_CNT_EN
   ,
   output word_t         fetch_cnt,
   output word_t         stall_cnt
`endif
);

   word_t        r_pc;
   word_t        r_pend_target;
   fetch_state_t r_state;
   logic         r_imemren;

   logic         w_redir;
   word_t        w_target;
   word_t        w_pc_plus4;
   logic         w_halted;

   assign w_pc_plus4    = pc_plus4(r_pc);
   assign w_halted      = (r_state == HALT);
   assign imem.imemaddr = r_pc;
   assign imem.imemREN  = r_imemren;

   // Redirect decode from EX: jumps always redirect, branches only when taken.
   always_comb begin
      w_redir  = 1'b0;
      w_target = 32'h0;
      case (pc_src)
         PC_BR: begin
            w_redir  = branch_sel;
            w_target = branch_addr;
         end
         PC_J: begin
            w_redir  = 1'b1;
            w_target = jump_addr;
         end
         PC_JR: begin
            w_redir  = 1'b1;
            w_target = jr_addr;
         end
         default: begin
            w_redir  = 1'b0;
            w_target = 32'h0;
         end
      endcase
   end

   // PC update and fetch FSM; a redirect seen during a stall is parked until pc_en.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc          <= PC0;
         r_state       <= FETCH;
         r_pend_target <= 32'h0;
         r_imemren     <= 1'b0;
      end else if (halt) begin
         r_state       <= HALT;
         r_pend_target <= 32'h0;
         r_imemren     <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               r_imemren <= 1'b1;
               if (pc_en) begin
                  r_pc <= w_redir ? w_target : w_pc_plus4;
               end else if (w_redir) begin
                  r_pend_target <= w_target;
                  r_state       <= PEND;
               end
            end
            PEND: begin
               r_imemren <= 1'b1;
               if (pc_en) begin
                  r_pc          <= w_redir ? w_target : r_pend_target;
                  r_pend_target <= 32'h0;
                  r_state       <= FETCH;
               end else if (w_redir) begin
                  r_pend_target <= w_target;
               end
            end
            HALT: begin
               r_imemren <= 1'b0;
            end
            default: begin
               r_state   <= FETCH;
               r_imemren <= 1'b0;
            end
         endcase
      end
   end

   if_id_latch u_if_id (
      .CLK      (CLK),
      .RST      (RST),
      .i_flush  (flushed1),
      .i_en     (id_en1),
      .i_halted (w_halted),
      .i_hit    (imem.ihit),
      .i_instr  (imem.imemload),
      .i_npc    (w_pc_plus4),
      .o_instr  (instr_id),
      .o_npc    (npc_id),
      .o_valid  (valid_id)
   );

`ifdef FETCH_PERF_CNT_EN
   word_t r_fetch_cnt;
   word_t r_stall_cnt;

   // Delivered-instruction and stalled-cycle counters, free-running with wrap.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_fetch_cnt <= 32'h0;
         r_stall_cnt <= 32'h0;
      end else begin
         if (id_en1 && !flushed1 && imem.ihit) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (!w_halted && !pc_en) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign fetch_cnt = r_fetch_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model of the fetch stage.
module tb_fetch_unit;
   import cpu_types_pkg::*;
   import diaosi_types_pkg::*;

   logic   CLK = 1'b0;
   logic   RST;
   logic   pc_en, flushed1, id_en1, branch_sel, halt;
   PCSrc_t pc_src;
   word_t  branch_addr, jump_addr, jr_addr;
   word_t  instr_id, npc_id;
   logic   valid_id;
`ifdef FETCH_PERF_CNT_EN
   word_t  fetch_cnt, stall_cnt;
`endif

   fetch_unit_if imem_bus ();

   fetch_unit dut (
      .CLK         (CLK),
      .RST         (RST),
      .imem        (imem_bus.master),
      .pc_en       (pc_en),
      .flushed1    (flushed1),
      .id_en1      (id_en1),
      .pc_src      (pc_src),
      .branch_sel  (branch_sel),
      .branch_addr (branch_addr),
      .jump_addr   (jump_addr),
      .jr_addr     (jr_addr),
      .halt        (halt),
      .instr_id    (instr_id),
      .npc_id      (npc_id),
      .valid_id    (valid_id)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt   (fetch_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   word_t m_pc, m_pend_tgt, m_instr, m_npc, m_fetch_cnt, m_stall_cnt;
   bit    m_pending, m_halted, m_valid, m_ren;

   task automatic model_reset();
      m_pc = 32'h0; m_pend_tgt = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
      m_pending = 1'b0; m_halted = 1'b0; m_valid = 1'b0; m_ren = 1'b0;
      m_fetch_cnt = 32'h0; m_stall_cnt = 32'h0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      bit    rd;
      word_t tgt;
      word_t pc_old;
      bit    halted_old;
      if (RST) begin
         model_reset();
         return;
      end
      pc_old = m_pc;
      halted_old = m_halted;
      rd = 1'b0;
      tgt = 32'h0;
      if (pc_src == PC_J) begin rd = 1'b1; tgt = jump_addr; end
      else if (pc_src == PC_JR) begin rd = 1'b1; tgt = jr_addr; end
      else if (pc_src == PC_BR && branch_sel) begin rd = 1'b1; tgt = branch_addr; end

      if (flushed1) begin
         m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
      end else if (id_en1) begin
         m_instr = imem_bus.imemload;
         m_npc   = pc_old + 32'd4;
         m_valid = imem_bus.ihit && !halted_old;
      end else if (halted_old) begin
         m_valid = 1'b0;
      end

      if (id_en1 && !flushed1 && imem_bus.ihit) m_fetch_cnt = m_fetch_cnt + 32'd1;
      if (!halted_old && !pc_en) m_stall_cnt = m_stall_cnt + 32'd1;

      if (halt) begin
         m_halted = 1'b1; m_pending = 1'b0; m_ren = 1'b0;
      end else if (halted_old) begin
         m_ren = 1'b0;
      end else begin
         m_ren = 1'b1;
         if (pc_en) begin
            if (rd) m_pc = tgt;
            else if (m_pending) m_pc = m_pend_tgt;
            else m_pc = pc_old + 32'd4;
            m_pending = 1'b0;
         end else if (rd) begin
            m_pending = 1'b1;
            m_pend_tgt = tgt;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      pc_en = 1'b0; flushed1 = 1'b0; id_en1 = 1'b0; branch_sel = 1'b0; halt = 1'b0;
      pc_src = PC_SEQ; branch_addr = 32'h0; jump_addr = 32'h0; jr_addr = 32'h0;
      imem_bus.ihit = 1'b0; imem_bus.imemload = 32'h0;
      model_reset();
      tick();
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", imem_bus.imemaddr, 32'h0); end
      n_tests++; if (imem_bus.imemREN !== 1'b0) begin n_fail++; $display("FAIL reset_ren got=%b exp=0", imem_bus.imemREN); end
      n_tests++; if (valid_id !== 1'b0 || instr_id !== 32'h0 || npc_id !== 32'h0) begin n_fail++; $display("FAIL reset_ifid got=%b/%h/%h exp=0/0/0", valid_id, instr_id, npc_id); end
   endtask

   task automatic test_sequential();
      word_t ld;
      RST = 1'b0; pc_en = 1'b1; id_en1 = 1'b1; imem_bus.ihit = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         ld = $urandom;
         imem_bus.imemload = ld;
         tick();
         n_tests++; if (imem_bus.imemaddr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc step=%0d got=%h exp=%h", i, imem_bus.imemaddr, 32'(4 * i)); end
         n_tests++; if (imem_bus.imemREN !== 1'b1) begin n_fail++; $display("FAIL seq_ren step=%0d got=%b exp=1", i, imem_bus.imemREN); end
         n_tests++; if (instr_id !== ld || npc_id !== 32'(4 * i) || valid_id !== 1'b1) begin n_fail++; $display("FAIL seq_ifid step=%0d got=%h/%h/%b exp=%h/%h/1", i, instr_id, npc_id, valid_id, ld, 32'(4 * i)); end
      end
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'h10) begin n_fail++; $display("FAIL seq_pc10 got=%h exp=10", imem_bus.imemaddr); end
   endtask

   task automatic test_branch();
      pc_src = PC_BR; branch_sel = 1'b1; branch_addr = 32'h40;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'h40) begin n_fail++; $display("FAIL br_taken got=%h exp=40", imem_bus.imemaddr); end
      pc_src = PC_J; jump_addr = 32'h10;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'h10) begin n_fail++; $display("FAIL jump got=%h exp=10", imem_bus.imemaddr); end
      pc_src = PC_BR; branch_sel = 1'b0;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'h14) begin n_fail++; $display("FAIL br_not_taken got=%h exp=14", imem_bus.imemaddr); end
   endtask

   task automatic test_pending();
      pc_en = 1'b0; pc_src = PC_J; jump_addr = 32'h80;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'h14) begin n_fail++; $display("FAIL pend_hold1 got=%h exp=14", imem_bus.imemaddr); end
      pc_src = PC_JR; jr_addr = 32'hC0;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'h14) begin n_fail++; $display("FAIL pend_hold2 got=%h exp=14", imem_bus.imemaddr); end
      pc_en = 1'b1; pc_src = PC_SEQ;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'hC0) begin n_fail++; $display("FAIL pend_newest got=%h exp=c0", imem_bus.imemaddr); end
   endtask

   task automatic test_flush();
      word_t other;
      pc_en = 1'b0; flushed1 = 1'b1; id_en1 = 1'b1; imem_bus.ihit = 1'b1;
      imem_bus.imemload = 32'h8C220004;
      tick();
      n_tests++; if (instr_id !== 32'h0 || valid_id !== 1'b0 || npc_id !== 32'h0) begin n_fail++; $display("FAIL flush got=%h/%b/%h exp=0/0/0", instr_id, valid_id, npc_id); end
      flushed1 = 1'b0;
      tick();
      n_tests++; if (instr_id !== 32'h8C220004 || npc_id !== 32'hC4 || valid_id !== 1'b1) begin n_fail++; $display("FAIL ifid_load got=%h/%h/%b exp=8c220004/c4/1", instr_id, npc_id, valid_id); end
      id_en1 = 1'b0;
      other = 32'h12345678;
      imem_bus.imemload = other;
      tick();
      n_tests++; if (instr_id !== 32'h8C220004 || npc_id !== 32'hC4 || valid_id !== 1'b1) begin n_fail++; $display("FAIL ifid_hold got=%h/%h/%b exp=8c220004/c4/1", instr_id, npc_id, valid_id); end
   endtask

   task automatic test_halt();
      pc_en = 1'b1; pc_src = PC_J; jump_addr = 32'h40; halt = 1'b1;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'hC0 || imem_bus.imemREN !== 1'b0) begin n_fail++; $display("FAIL halt_entry got=%h/%b exp=c0/0", imem_bus.imemaddr, imem_bus.imemREN); end
      halt = 1'b0; id_en1 = 1'b1; imem_bus.ihit = 1'b1;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'hC0 || imem_bus.imemREN !== 1'b0 || valid_id !== 1'b0) begin n_fail++; $display("FAIL halt_stay got=%h/%b/%b exp=c0/0/0", imem_bus.imemaddr, imem_bus.imemREN, valid_id); end
      pc_src = PC_SEQ;
      RST = 1'b1;
      #2;
      model_reset();
      n_tests++; if (imem_bus.imemaddr !== 32'h0 || valid_id !== 1'b0 || imem_bus.imemREN !== 1'b0) begin n_fail++; $display("FAIL async_reset got=%h/%b/%b exp=0/0/0", imem_bus.imemaddr, valid_id, imem_bus.imemREN); end
      tick();
      RST = 1'b0;
      tick();
      n_tests++; if (imem_bus.imemREN !== 1'b1 || imem_bus.imemaddr !== 32'h4) begin n_fail++; $display("FAIL post_reset got=%b/%h exp=1/4", imem_bus.imemREN, imem_bus.imemaddr); end
   endtask

   task automatic test_wrap();
      pc_en = 1'b1; pc_src = PC_J; jump_addr = 32'hFFFFFFFC;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_setup got=%h exp=fffffffc", imem_bus.imemaddr); end
      pc_src = PC_SEQ; id_en1 = 1'b1;
      tick();
      n_tests++; if (imem_bus.imemaddr !== 32'h0 || npc_id !== 32'h0) begin n_fail++; $display("FAIL wrap got=%h/%h exp=0/0", imem_bus.imemaddr, npc_id); end
`ifdef FETCH_PERF_CNT_EN
      RST = 1'b1;
      tick();
      RST = 1'b0; pc_en = 1'b0; flushed1 = 1'b0; id_en1 = 1'b1; imem_bus.ihit = 1'b1;
      repeat (5) tick();
      n_tests++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=5", stall_cnt); end
      n_tests++; if (fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL fetch_cnt got=%0d exp=5", fetch_cnt); end
`endif
   endtask

   task automatic test_random();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int c = 0; c < 400; c++) begin
         pc_en = ($urandom_range(0, 3) != 0);
         flushed1 = ($urandom_range(0, 7) == 0);
         id_en1 = ($urandom_range(0, 3) != 0);
         imem_bus.ihit = ($urandom_range(0, 4) != 0);
         imem_bus.imemload = $urandom;
         pc_src = PCSrc_t'($urandom_range(0, 3));
         branch_sel = $urandom_range(0, 1);
         branch_addr = $urandom & 32'hFFFFFFFC;
         jump_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
         jr_addr = $urandom & 32'hFFFFFFFC;
         halt = ($urandom_range(0, 49) == 0);
         RST = ($urandom_range(0, 59) == 0);
         tick();
         n_tests++; if (imem_bus.imemaddr !== m_pc) begin n_fail++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", c, imem_bus.imemaddr, m_pc); end
         n_tests++; if (imem_bus.imemREN !== m_ren) begin n_fail++; $display("FAIL rand_ren cyc=%0d got=%b exp=%b", c, imem_bus.imemREN, m_ren); end
         n_tests++; if (instr_id !== m_instr) begin n_fail++; $display("FAIL rand_instr cyc=%0d got=%h exp=%h", c, instr_id, m_instr); end
         n_tests++; if (npc_id !== m_npc) begin n_fail++; $display("FAIL rand_npc cyc=%0d got=%h exp=%h", c, npc_id, m_npc); end
         n_tests++; if (valid_id !== m_valid) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, valid_id, m_valid); end
`ifdef FETCH_PERF_CNT_EN
         n_tests++; if (fetch_cnt !== m_fetch_cnt || stall_cnt !== m_stall_cnt) begin n_fail++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, fetch_cnt, stall_cnt, m_fetch_cnt, m_stall_cnt); end
`endif
      end
      RST = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_pending();
      test_flush();
      test_halt();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
